// File: rtl/mem_align_unit_if.sv
// Request/response and memory-port bundle for mem_align_unit.
// slave: the alignment unit's view; master: the core plus memory side.
interface mem_align_unit_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned B = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misaligned;
    logic            mem_read;
    logic            mem_write;
    logic [B-1:0]    mem_byte_enable;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_resp;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: splits bus-word-crossing accesses into two beats and extends loads.
// Optional MEM_ALIGN_TRAP_EN: crossing accesses are not executed and are flagged as misaligned.
module mem_align_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OFFW = $clog2(XLEN / 8)
) (
    input logic             clk,
    input logic             rst,
    mem_align_unit_if.slave bus
);
    localparam int unsigned B  = XLEN / 8;
    localparam int unsigned B2 = 2 * B;

    typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StDone} state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic            signed_q, signed_d;
    logic [1:0]      size_q, size_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            split_q, split_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [B-1:0]    be2_q, be2_d;
    logic [XLEN-1:0] wd2_q, wd2_d;
    logic [XLEN-1:0] beat1_q, beat1_d;
    logic            req_ready_q, req_ready_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [B-1:0]    be_q, be_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
`ifdef MEM_ALIGN_TRAP_EN
    logic            resp_mis_q, resp_mis_d;
`endif

    logic [1:0]        req_size_eff;
    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_n;
    logic              req_split;
    logic [B2-1:0]     lane_mask;
    logic [B2-1:0]     req_be_full;
    logic [2*XLEN-1:0] req_wd_full;
    logic              strobe;

    // Join the two beats, keep the accessed bytes and extend from the top kept bit.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] b1,
        input logic [XLEN-1:0] b2,
        input logic [OFFW-1:0] off,
        input logic [1:0]      size,
        input logic            sgn
    );
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] keep;
        int unsigned     nbits;
        logic            msb;
        raw   = (b1 >> {off, 3'b000}) | (b2 << (XLEN - 8 * 32'(off)));
        nbits = 32'd8 << size;
        keep  = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        msb   = |(raw & keep & ~(keep >> 1));
        return (sgn && msb) ? (raw | ~keep) : (raw & keep);
    endfunction

    always_comb begin
        req_size_eff = bus.req_size;
        if (XLEN == 32 && bus.req_size == 2'd3) req_size_eff = 2'd2;
        req_off     = bus.req_addr[OFFW-1:0];
        req_n       = 4'd1 << req_size_eff;
        req_split   = (32'(req_off) + 32'(req_n)) > B;
        lane_mask   = B2'((32'd1 << req_n) - 32'd1);
        // Upper halves of the double-width shifts are exactly the second-beat lanes/data.
        req_be_full = lane_mask << req_off;
        req_wd_full = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
    end

    assign strobe = mem_read_q | mem_write_q;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        signed_d     = signed_q;
        size_d       = size_q;
        off_d        = off_q;
        split_d      = split_q;
        base_d       = base_q;
        be2_d        = be2_q;
        wd2_d        = wd2_q;
        beat1_d      = beat1_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        be_d         = be_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
`ifdef MEM_ALIGN_TRAP_EN
        resp_mis_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    signed_d = bus.req_signed;
                    size_d   = req_size_eff;
                    off_d    = req_off;
                    split_d  = req_split;
                    base_d   = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    be2_d    = req_be_full[B2-1:B];
                    wd2_d    = req_wd_full[2*XLEN-1:XLEN];
`ifdef MEM_ALIGN_TRAP_EN
                    if (req_split) begin
                        state_d      = StDone;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d     = StBeat1;
                        mem_read_d  = ~bus.req_write;
                        mem_write_d = bus.req_write;
                        be_d        = req_be_full[B-1:0];
                        maddr_d     = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        mwdata_d    = req_wd_full[XLEN-1:0];
                    end
                end
            end
            StBeat1: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    beat1_d     = bus.mem_rdata;
                    if (split_q) begin
                        state_d  = StBeat2;
                        maddr_d  = base_q + XLEN'(B);
                        be_d     = be2_q;
                        mwdata_d = wd2_q;
                    end else begin
                        state_d      = StDone;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = write_q ? '0 :
                            load_extend(bus.mem_rdata, '0, off_q, size_q, signed_q);
                    end
                end
            end
            StBeat2: begin
                // Entered with strobes low; they rise one cycle later to leave a gap.
                if (strobe && bus.mem_resp) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 :
                        load_extend(beat1_q, bus.mem_rdata, off_q, size_q, signed_q);
                end else begin
                    mem_read_d  = ~write_q;
                    mem_write_d = write_q;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            base_q       <= '0;
            be2_q        <= '0;
            wd2_q        <= '0;
            beat1_q      <= '0;
            req_ready_q  <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            be_q         <= '0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef MEM_ALIGN_TRAP_EN
            resp_mis_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
            size_q       <= size_d;
            off_q        <= off_d;
            split_q      <= split_d;
            base_q       <= base_d;
            be2_q        <= be2_d;
            wd2_q        <= wd2_d;
            beat1_q      <= beat1_d;
            req_ready_q  <= req_ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            be_q         <= be_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef MEM_ALIGN_TRAP_EN
            resp_mis_q   <= resp_mis_d;
`endif
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_address     = maddr_q;
    assign bus.mem_wdata       = mwdata_q;
`ifdef MEM_ALIGN_TRAP_EN
    assign bus.resp_misaligned = resp_mis_q;
`else
    assign bus.resp_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit: byte-window reference model, memory responder, response monitor.
// Honours MEM_ALIGN_TRAP_EN the same way the design does.
module tb_mem_align_unit;
    localparam int unsigned XLEN = 32;
    localparam int unsigned B    = XLEN / 8;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    mem_align_unit_if #(.XLEN(XLEN)) bus ();
    mem_align_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t beat_q[$];
    resp_t resp_q[$];
    bit    auto_mem = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: view the two bus words as one little-endian byte window.
    task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] r1, input logic [31:0] r2,
                         output beat_t b1, output beat_t b2, output int nb, output resp_t r);
        int          off, n;
        bit          split;
        logic [7:0]  win [2*B];
        logic [7:0]  wb  [2*B];
        logic [7:0]  be;
        logic [31:0] v, w1, w2, base;
        off   = int'(addr % B);
        n     = (sz == 2'd3) ? 4 : (1 << sz);
        split = (off + n) > B;
        base  = addr - 32'(off);
        b1    = '0;
        b2    = '0;
        for (int k = 0; k < 2 * B; k++) begin
            win[k] = (k < B) ? r1[8*k +: 8] : r2[8*(k-B) +: 8];
            wb[k]  = 8'h00;
        end
        be = 8'h00;
        v  = 32'h0;
        for (int k = 0; k < n; k++) begin
            be[off+k]  = 1'b1;
            v[8*k +: 8] = win[off+k];
        end
        if (sg && n < B && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        for (int k = 0; k < B; k++) wb[off+k] = wd[8*k +: 8];
        for (int k = 0; k < B; k++) begin
            w1[8*k +: 8] = wb[k];
            w2[8*k +: 8] = wb[k+B];
        end
        b1 = '{~wr, wr, base, be[3:0], w1, r1, ~split};
        b2 = '{~wr, wr, base + 32'd4, be[7:4], w2, r2, 1'b1};
        nb = split ? 2 : 1;
        r  = '{wr ? 32'h0 : v, 1'b0};
`ifdef MEM_ALIGN_TRAP_EN
        if (split) begin
            nb = 0;
            r  = '{32'h0, 1'b1};
        end
`endif
    endtask

    task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int nb, input beat_t b1, input beat_t b2, input resp_t r);
        int cyc;
        if (nb > 0) beat_q.push_back(b1);
        if (nb > 1) beat_q.push_back(b2);
        resp_q.push_back(r);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        chk("accept drops req_ready", bus.req_ready, 0);
        chk("strobe one cycle after accept", bus.mem_read | bus.mem_write, nb > 0);
        if (nb == 0) chk("trap resp one cycle after accept", bus.resp_valid, 1);
        cyc = 0;
        while (!bus.req_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL request timeout: req_ready still %b after %0d cycles", bus.req_ready, cyc);
        end
    endtask

    task automatic run_model(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] r1, input logic [31:0] r2);
        beat_t b1, b2;
        int    nb;
        resp_t r;
        model(wr, sz, sg, addr, wd, r1, r2, b1, b2, nb, r);
        run(wr, sz, sg, addr, wd, nb, b1, b2, r);
    endtask

    // Memory side: check each beat against the scoreboard and answer after a random delay.
    initial begin : responder
        beat_t b;
        int    dly;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = $urandom;
        forever begin
            @(negedge clk);
            if (auto_mem && rst && (bus.mem_read || bus.mem_write)) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected beat: addr %h read %b write %b", bus.mem_address,
                             bus.mem_read, bus.mem_write);
                    b = '0;
                end else begin
                    b = beat_q.pop_front();
                    chk("beat mem_read", bus.mem_read, b.rd);
                    chk("beat mem_write", bus.mem_write, b.wr);
                    chk("beat address", bus.mem_address, b.addr);
                    chk("beat byte_enable", bus.mem_byte_enable, b.be);
                    chk("beat wdata", bus.mem_wdata, b.wdata);
                end
                dly = $urandom_range(0, 2);
                repeat (dly) @(negedge clk);
                bus.mem_rdata = b.rdata;
                bus.mem_resp  = 1'b1;
                @(negedge clk);
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = $urandom;
                chk("strobes drop after mem_resp", bus.mem_read | bus.mem_write, 0);
                if (b.last) chk("resp_valid after final mem_resp", bus.resp_valid, 1);
            end
        end
    end

    initial begin : monitor
        resp_t r;
        logic  prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev) chk("resp_valid one cycle", bus.resp_valid, 0);
            prev = bus.resp_valid;
            if (bus.resp_valid) begin
                checks++;
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected resp_valid: rdata %h", bus.resp_rdata);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, r.rdata);
                    chk("resp_misaligned", bus.resp_misaligned, r.mis);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        wr, sg;
        logic [1:0]  sz;
        logic [31:0] addr;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", bus.req_ready, 1);
        chk("reset resp_valid", bus.resp_valid, 0);
        chk("reset resp_rdata", bus.resp_rdata, 0);
        chk("reset resp_misaligned", bus.resp_misaligned, 0);
        chk("reset mem strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("reset byte_enable", bus.mem_byte_enable, 0);
        chk("reset address", bus.mem_address, 0);
        chk("reset wdata", bus.mem_wdata, 0);
        rst = 1'b1;

        // Directed cases valid in both builds.
        run(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1,
            '{1'b1, 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b1}, '0,
            '{32'hDEADBEEF, 1'b0});
        run(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 1,
            '{1'b1, 1'b0, 32'h4, 4'b1000, 32'h0, 32'h80000000, 1'b1}, '0,
            '{32'hFFFFFF80, 1'b0});
        run(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 1,
            '{1'b1, 1'b0, 32'h4, 4'b1000, 32'h0, 32'h80000000, 1'b1}, '0,
            '{32'h00000080, 1'b0});
`ifdef MEM_ALIGN_TRAP_EN
        run(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, '0, '0, '{32'h0, 1'b1});
`else
        run(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 2,
            '{1'b1, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hAB000000, 1'b0},
            '{1'b1, 1'b0, 32'h104, 4'b0001, 32'h0, 32'h000000CD, 1'b1},
            '{32'hFFFFCDAB, 1'b0});
        run(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 2,
            '{1'b0, 1'b1, 32'h100, 4'b1100, 32'h33440000, 32'h5A5A5A5A, 1'b0},
            '{1'b0, 1'b1, 32'h104, 4'b0011, 32'h00001122, 32'hA5A5A5A5, 1'b1},
            '{32'h0, 1'b0});
        run(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 2,
            '{1'b1, 1'b0, 32'hFFFFFFFC, 4'b1100, 32'h0, 32'h12345678, 1'b0},
            '{1'b1, 1'b0, 32'h00000000, 4'b0011, 32'h0, 32'h9ABCDEF0, 1'b1},
            '{32'hDEF01234, 1'b0});

        // Reset during the second beat; a late mem_resp in IDLE must be ignored.
        auto_mem = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'hFFFFFFFE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort beat1 address", bus.mem_address, 32'hFFFFFFFC);
        @(negedge clk); bus.mem_resp = 1'b1;
        @(negedge clk); bus.mem_resp = 1'b0;
        @(posedge clk); #1;
        chk("abort beat2 mem_read", bus.mem_read, 1);
        chk("abort beat2 address", bus.mem_address, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort strobes low", {bus.mem_read, bus.mem_write}, 0);
        chk("abort req_ready", bus.req_ready, 1);
        chk("abort byte_enable cleared", bus.mem_byte_enable, 0);
        rst = 1'b1;
        @(negedge clk); bus.mem_resp = 1'b1;
        @(negedge clk); bus.mem_resp = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("late mem_resp ignored strobes", {bus.mem_read, bus.mem_write}, 0);
            chk("late mem_resp ignored ready", bus.req_ready, 1);
        end
        auto_mem = 1'b1;
`endif

        for (int i = 0; i < 300; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if (i % 8 == 0) addr[31:3] = '1;
            run_model(wr, sz, sg, addr, $urandom, $urandom, $urandom);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("beat queue drained", beat_q.size(), 0);
        chk("resp queue drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Parametrised load/store alignment unit between the multicycle core's memory-request logic and the existing memory port (mem_read/mem_write/mem_resp handshake).
- Accepts byte/half/word/double requests at any byte address. Misaligned accesses that cross a bus-word boundary are split into two bus beats.
- Generates byte enables and shifted write data, reassembles read data, and sign- or zero-extends it.

Parameters:
- XLEN, 32, data and address width in bits; legal values 32 or 64. B = XLEN/8 bytes per bus word.
- OFFW, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double (3 legal only when XLEN=64)
- req_signed  in  1  sign-extend load result
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores
- resp_misaligned  out  1  misaligned-trap flag (see Optional Feature)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_byte_enable  out  B  byte lanes
- mem_address  out  XLEN  B-aligned bus address
- mem_wdata  out  XLEN  bus write data
- mem_rdata  in  XLEN  bus read data
- mem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset (rst==0 at a clk edge):
  - FSM returns to IDLE; beat and data registers are cleared.
  - Output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_read=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0.
- FSM states: IDLE, BEAT1, BEAT2, DONE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and compute: off = addr[OFFW-1:0], n = 1<<req_size, split = (off+n > B).
  - Next state: BEAT1.
- BEAT1:
  - mem_address = addr with low OFFW bits cleared.
  - mem_byte_enable = ((1<<n)-1) << off, truncated to B bits.
  - mem_wdata = req_wdata << 8*off.
  - mem_read = !req_write and mem_write = req_write, held high until mem_resp.
  - On mem_resp: capture mem_rdata, drop request strobes. Next state is BEAT2 if split, otherwise DONE.
- BEAT2:
  - mem_address = BEAT1 address + B, modulo 2^XLEN (0xFFFFFFFC + 4 wraps to 0).
  - mem_byte_enable = ((1<<n)-1) >> (B-off).
  - mem_wdata = req_wdata >> 8*(B-off).
  - On mem_resp: capture mem_rdata. Next state: DONE.
- DONE:
  - resp_valid=1 for exactly one cycle. Next state: IDLE.
  - resp_rdata = ((beat1 >> 8*off) | (beat2 << 8*(B-off))), masked to n bytes, then sign-extended from bit 8n-1 if req_signed, else zero-extended. The beat2 term is 0 when not split.
- Request strobes drop for at least one cycle between BEAT1 and BEAT2.
- Latency:
  - Request accepted at edge T; mem strobes are high from T+1.
  - resp_valid is high in the cycle after the final mem_resp.
  - The next request can be accepted the cycle after resp_valid.
- mem_resp arriving in IDLE or DONE is ignored.
- Reset mid-operation: strobes deassert on the next edge. No resp_valid is issued. A mem_resp for the abandoned beat that arrives later in IDLE is ignored.
- req_size=3 with XLEN=32 is treated as size 2.

Optional Feature:
- Macro: MEM_ALIGN_TRAP_EN.
- When defined:
  - Any request with split=1 issues no memory beat; the FSM goes IDLE -> DONE.
  - resp_valid=1 and resp_misaligned=1 in the cycle after acceptance; resp_rdata=0.
  - Non-split requests behave as above with resp_misaligned=0.
- When undefined: resp_misaligned is tied 0 and all splits execute as two beats.

Test Plan:
- Aligned load: XLEN=32, lw at 0x100, mem_rdata=0xDEADBEEF -> one beat, mem_address=0x100, be=4'b1111, resp_rdata=0xDEADBEEF.
- Split signed half load: lh at 0x103; beat1 addr=0x100 be=4'b1000 rdata=0xAB000000; beat2 addr=0x104 be=4'b0001 rdata=0x000000CD -> resp_rdata=0xFFFFCDAB.
- Split store: sw 0x11223344 at 0x102 -> beat1 addr=0x100 be=4'b1100 wdata=0x33440000; beat2 addr=0x104 be=4'b0011 wdata=0x00001122; resp_valid pulse with resp_rdata=0.
- Byte extension: lb / lbu at 0x7 with rdata=0x80000000 -> resp_rdata=0xFFFFFF80 / 0x00000080; be=4'b1000.
- Wrap and reset: lw at 0xFFFFFFFE -> beat2 addr=0x00000000. Repeat, pulling rst low during beat2 -> strobes low next cycle, req_ready=1, no resp_valid; a late mem_resp is ignored.
- MEM_ALIGN_TRAP_EN defined: lw at 0x101 -> no mem_read, resp_valid and resp_misaligned high one cycle after acceptance; lw at 0x100 completes normally.
